universal_shift_register_n: RTL
===============================

# universal_shift_register_n

Parametrised universal shift register: the next generation of the team's 4-bit shift register, generalised to WIDTH bits and extended with logical/rotate/arithmetic modes, serial fill/out, and multi-position shifts with a busy/done handshake. It shifts one position per clock. It sits in the datapath wherever parallel load plus controlled shifting is needed, such as serialisers, barrel-less multiply/divide steps and bit-stream alignment.

## Interface
Parameters:
- WIDTH, 4, register width in bits (≥2)
- AMT_W, 3, width of the shift-amount input

Ports:
- clk  in  1  clock, rising-edge active
- reset  in  1  asynchronous, active-low reset
- d  in  WIDTH  parallel load data
- load  in  1  parallel load request
- shiftLeft  in  1  start left shift (toward MSB)
- shiftRight  in  1  start right shift (toward LSB)
- mode  in  2  00 logical, 01 rotate, 10 arithmetic, 11 treated as logical
- amount  in  AMT_W  number of positions to shift
- serialIn  in  1  fill bit for logical mode, sampled live on each shift edge
- q  out  WIDTH  register contents
- shiftOut  out  1  last bit shifted out of the register
- busy  out  1  multi-position shift in progress
- done  out  1  one-cycle pulse, shift command complete

## Operation
- Reset (reset=0, asynchronous): q=0, shiftOut=0, busy=0, done=0, internal remaining count=0, state IDLE.
- States:
  - IDLE (busy=0)
  - SHIFT (busy=1, remaining≠0)
- Command priority when sampled: load > shiftLeft > shiftRight.
- load (any state): q←d on the edge. Aborts any SHIFT, so remaining←0 and busy←0. No done pulse. shiftOut is unchanged.
- In IDLE, shiftLeft/shiftRight latch direction and mode into internal registers and accept amount N:
  - N=0: q unchanged and IDLE is kept. done=1 for the next cycle.
  - N≥1: one shift is performed on the accepting edge and remaining←N−1. If N=1, done=1 next cycle and the block stays in IDLE. Otherwise it enters SHIFT.
- In SHIFT, each edge performs one shift with the latched direction/mode and decrements remaining. When remaining reaches 0, the block returns to IDLE and done=1 for one cycle.
- In SHIFT, shiftLeft, shiftRight, amount and mode inputs are ignored. serialIn is still sampled each edge.
- Single-step rules:
  - Left logical: q←{q[W−2:0],serialIn}, shiftOut←q[W−1].
  - Right logical: q←{serialIn,q[W−1:1]}, shiftOut←q[0].
  - Left rotate: q←{q[W−2:0],q[W−1]}, shiftOut←q[W−1].
  - Right rotate: q←{q[0],q[W−1:1]}, shiftOut←q[0].
  - Left arithmetic: same as left logical with fill 0.
  - Right arithmetic: q←{q[W−1],q[W−1:1]} (sign preserved), shiftOut←q[0].
- N greater than WIDTH is legal:
  - Logical/arithmetic modes keep shifting, so the register fully flushes to fill bits.
  - Rotate wraps around naturally.
- shiftOut holds its value between shifts.

## Timing
- Load latency 1 edge.
- An N-position shift (N≥1) takes N edges:
  - q reflects the k-th shift after edge k.
  - busy is high from after edge 1 until after edge N, i.e. N−1 cycles.
  - done is high during the single cycle after edge N.
- done is never asserted in the same cycle as busy. A new command may be issued in the done cycle and is accepted.
- Asynchronous reset mid-SHIFT clears everything immediately, with no done pulse.
- Simultaneous load and shift: load wins.
- Simultaneous shiftLeft and shiftRight: left wins.

## Test plan
- Reset: drive reset=0 during a 3-position shift -> q=0000, busy=0, done=0 immediately. After release with inputs idle, all outputs stay 0.
- Load and single logical shift, WIDTH=4:
  - Load d=1010 -> q=1010 after 1 edge, done=0.
  - Then shiftLeft, mode=00, amount=1, serialIn=1 -> q=0101, shiftOut=1, done pulses one cycle, busy never high.
- Rotate right multi-step: q=1011, shiftRight, mode=01, amount=3 -> q=1101, 1110, 0111 on successive edges. busy high 2 cycles, then done pulse. shiftOut=0.
- Arithmetic right and flush: q=1000, mode=10, amount=2 -> 1100, 1110. Then q=0110, logical left, amount=6, serialIn=0 -> q=0000 after 6 edges, done once.
- Abort and priorities:
  - During a 5-position shift, load d=0011 at edge 3 -> q=0011, busy=0, no done.
  - In IDLE, shiftLeft and shiftRight together -> left shift.
  - amount=0 -> q unchanged, done pulse.

Source files
------------

// File: rtl/universal_shift_register_n_if.sv
// Bus bundle for universal_shift_register_n: command and data inputs plus register/handshake outputs.
// Signal names are fixed by the block's external interface.
interface universal_shift_register_n_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
);
    logic [WIDTH-1:0] d;
    logic             load;
    logic             shiftLeft;
    logic             shiftRight;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic             serialIn;
    logic [WIDTH-1:0] q;
    logic             shiftOut;
    logic             busy;
    logic             done;

    modport master (
        output d, load, shiftLeft, shiftRight, mode, amount, serialIn,
        input  q, shiftOut, busy, done
    );

    modport slave (
        input  d, load, shiftLeft, shiftRight, mode, amount, serialIn,
        output q, shiftOut, busy, done
    );
endinterface

// File: rtl/universal_shift_register_n.sv
// WIDTH-bit universal shift register: parallel load, logical/rotate/arithmetic shifts of
// N positions at one position per clock, with busy/done handshake and serial fill/out.
module universal_shift_register_n #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input logic                                  clk,
    input logic                                  reset,
    universal_shift_register_n_if.slave          bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    typedef enum logic [1:0] {
        MODE_LOGIC = 2'b00,
        MODE_ROT   = 2'b01,
        MODE_ARITH = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_r, q_n;
    logic             so_r, so_n;
    logic             done_r, done_n;
    logic [AMT_W-1:0] rem_r, rem_n;
    logic             dir_r, dir_n;
    mode_t            mode_r, mode_n;

    // One shift position; returns {shifted-out bit, new register value}.
    function automatic logic [WIDTH:0] step(
        input logic [WIDTH-1:0] cur,
        input logic             left,
        input mode_t            m,
        input logic             sin
    );
        logic fill;
        if (left) begin
            case (m)
                MODE_ROT:   fill = cur[WIDTH-1];
                MODE_ARITH: fill = 1'b0;
                default:    fill = sin;
            endcase
            step = {cur[WIDTH-1], cur[WIDTH-2:0], fill};
        end else begin
            case (m)
                MODE_ROT:   fill = cur[0];
                MODE_ARITH: fill = cur[WIDTH-1];
                default:    fill = sin;
            endcase
            step = {cur[0], fill, cur[WIDTH-1:1]};
        end
    endfunction

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        q_n     = q_r;
        so_n    = so_r;
        rem_n   = rem_r;
        dir_n   = dir_r;
        mode_n  = mode_r;
        done_n  = 1'b0;

        if (bus.load) begin
            q_n     = bus.d;
            rem_n   = '0;
            state_n = IDLE;
        end else if (state == IDLE) begin
            if (bus.shiftLeft || bus.shiftRight) begin
                dir_n  = bus.shiftLeft;
                mode_n = mode_t'(bus.mode);
                if (bus.amount == '0) begin
                    done_n = 1'b1;
                end else begin
                    {so_n, q_n} = step(q_r, bus.shiftLeft, mode_t'(bus.mode), bus.serialIn);
                    rem_n       = bus.amount - AMT_W'(1);
                    if (bus.amount == AMT_W'(1)) done_n  = 1'b1;
                    else                         state_n = SHIFT;
                end
            end
        end else begin
            // Command inputs are ignored here; only serialIn is still sampled.
            {so_n, q_n} = step(q_r, dir_r, mode_r, bus.serialIn);
            rem_n       = rem_r - AMT_W'(1);
            if (rem_r == AMT_W'(1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            q_r    <= '0;
            so_r   <= 1'b0;
            done_r <= 1'b0;
            rem_r  <= '0;
            dir_r  <= 1'b0;
            mode_r <= MODE_LOGIC;
        end else begin
            state  <= state_n;
            q_r    <= q_n;
            so_r   <= so_n;
            done_r <= done_n;
            rem_r  <= rem_n;
            dir_r  <= dir_n;
            mode_r <= mode_n;
        end
    end

    assign bus.q        = q_r;
    assign bus.shiftOut = so_r;
    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_r;
endmodule
